// File: rtl/fifo1c_arb_pkg.sv
// fifo1c_arb_pkg: shared FSM state type and default sizing for the FIFO write arbiter
package fifo1c_arb_pkg;
  typedef enum logic {IDLE, BURST} state_e;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first requester after last wins
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = last;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        gnt = '0;
        gnt[(int'(last) + k) % N] = 1'b1;
        idx = IW'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/fifo1c_wr_arb.sv
// fifo1c_wr_arb: burst round-robin write arbiter feeding a single-clock FIFO with occupancy tracking
module fifo1c_wr_arb
  import fifo1c_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*64-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_wrreq,
  output logic [63:0]                fifo_data,
  input  logic                       fifo_rdreq,
  input  logic                       fifo_empty,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [4:0]                 occ,
  output logic                       err,
  input  logic                       err_clr
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, owner_q, owner_d, pick_idx, sel;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [4:0] occ_q, occ_d;
  logic [63:0] data_q, data_d;
  logic [N_REQ-1:0] pick_gnt, rdy;
  logic wr_q, wr_d, err_q, err_d;
  logic space, accept, pop, under;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );
  assign space = int'(occ_q) < DEPTH;
  assign sel = (state_q == BURST) ? owner_q : pick_idx;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    rdy = '0;
    if (state_q == IDLE) begin
      rdy = space ? pick_gnt : '0;
      if (space && |req_valid) begin
        if (MAX_BURST == 1) begin
          last_d = pick_idx;
        end else begin
          state_d = BURST;
          owner_d = pick_idx;
          cnt_d = BW'(1);
        end
      end
    end else begin
      rdy[owner_q] = space;
      if (space && req_valid[owner_q]) cnt_d = cnt_q + 1'b1;
      if (!req_valid[owner_q] || cnt_d == BW'(MAX_BURST)) begin
        state_d = IDLE;
        last_d = owner_q;
        cnt_d = '0;
      end
    end
  end
  assign req_ready = rst ? '0 : rdy;
  assign accept = |(req_ready & req_valid);
  assign pop = fifo_rdreq & ~fifo_empty;
  assign under = pop && occ_q == 5'd0;
  always_comb begin
    occ_d = occ_q + {4'd0, accept} - {4'd0, pop & ~under};
    err_d = under | (err_q & ~err_clr);
    wr_d = accept;
    data_d = accept ? req_data[{sel, 6'd0} +: 64] : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(N_REQ - 1);
      owner_q <= '0;
      cnt_q <= '0;
      occ_q <= '0;
      wr_q <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      wr_q <= wr_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign fifo_wrreq = wr_q;
  assign fifo_data = data_q;
  assign grant_id = (state_q == BURST) ? owner_q : last_q;
  assign occ = occ_q;
  assign err = err_q;
endmodule
